// File: rtl/force_override_pkg.sv
// Shared types and the round-robin pick helper for the override controller.
// The pick helper works on a fixed 8-bit request vector so one function serves every N_REQ.
package force_override_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FORCE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of elig at or after ptr, wrapping at n (n <= MAX_REQ).
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] elig,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        rr_pick_t         res;
        logic [IDX_W-1:0] j;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = IDX_W'((int'(ptr) + k) % n);
            if (k < n && !res.valid && elig[j]) begin
                res.valid = 1'b1;
                res.idx   = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational winner search plus the registered priority pointer.
// The pointer moves to one past the finishing winner when the controller ends a lease.
module rr_arbiter
    import force_override_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] eligible,
    input  logic             ptr_adv,
    input  logic [IDX_W-1:0] ptr_from,
    output logic             pick_valid,
    output logic [IDX_W-1:0] pick_idx
);

    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   rr_ptr_next;
    logic [MAX_REQ-1:0] elig_ext;
    rr_pick_t           pick;

    assign elig_ext   = MAX_REQ'(eligible);
    assign pick       = rr_pick(elig_ext, rr_ptr_reg, N_REQ);
    assign pick_valid = pick.valid;
    assign pick_idx   = pick.idx;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (ptr_adv) begin
            rr_ptr_next = (ptr_from == IDX_W'(N_REQ - 1)) ? '0 : ptr_from + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/force_override_ctrl.sv
// Synthesizable force/release: grants one requester at a time a bounded lease on the
// output value, with a mandatory gap cycle between leases and a timeout lock-out mask.
module force_override_ctrl
    import force_override_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 2,
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [WIDTH-1:0]       func_val,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] force_val,
    output logic [N_REQ-1:0]       grant,
    output logic                   forced,
    output logic [WIDTH-1:0]       out_val,
    output logic                   timeout
);

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic               forced_reg, forced_next;
    logic               timeout_reg, timeout_next;
    logic [CNT_W-1:0]   lease_cnt_reg, lease_cnt_next;
    logic [IDX_W-1:0]   win_idx_reg, win_idx_next;
    logic [N_REQ-1:0]   to_mask_reg, to_mask_next;
    logic [N_REQ-1:0]   mask_set;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   pick_onehot;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               ptr_adv;
    logic               req_win;
    logic [WIDTH-1:0]   sel_val;
    logic [WIDTH-1:0]   slice_masked [N_REQ];

    assign eligible = req & ~to_mask_reg;
    assign req_win  = |(req & grant_reg);

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk        (clk),
        .rstn       (rstn),
        .eligible   (eligible),
        .ptr_adv    (ptr_adv),
        .ptr_from   (win_idx_reg),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    // Grant is one-hot, so an AND-OR across requesters selects the live winner slice.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign pick_onehot[gi]  = (pick_idx == IDX_W'(gi));
        assign slice_masked[gi] = grant_reg[gi] ? force_val[gi*WIDTH +: WIDTH] : '0;
    end

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_val = sel_val | slice_masked[i];
        end
    end

    assign out_val = forced_reg ? sel_val : func_val;
    assign grant   = grant_reg;
    assign forced  = forced_reg;
    assign timeout = timeout_reg;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        forced_next    = forced_reg;
        timeout_next   = 1'b0;
        lease_cnt_next = lease_cnt_reg;
        win_idx_next   = win_idx_reg;
        mask_set       = '0;
        ptr_adv        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next     = FORCE;
                    grant_next     = pick_onehot;
                    forced_next    = 1'b1;
                    lease_cnt_next = CNT_W'(1);
                    win_idx_next   = pick_idx;
                end
            end
            FORCE: begin
                // Release is tested first so a coincident timeout is dropped.
                if (!req_win) begin
                    state_next     = GAP;
                    grant_next     = '0;
                    forced_next    = 1'b0;
                    lease_cnt_next = '0;
                    ptr_adv        = 1'b1;
                end else if (lease_cnt_reg == CNT_W'(HOLD_MAX)) begin
                    state_next     = GAP;
                    grant_next     = '0;
                    forced_next    = 1'b0;
                    lease_cnt_next = '0;
                    timeout_next   = 1'b1;
                    mask_set       = grant_reg;
                    ptr_adv        = 1'b1;
                end else begin
                    lease_cnt_next = lease_cnt_reg + 1'b1;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next  = IDLE;
                grant_next  = '0;
                forced_next = 1'b0;
            end
        endcase
        to_mask_next = (to_mask_reg & req) | mask_set;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            forced_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
            lease_cnt_reg <= '0;
            win_idx_reg   <= '0;
            to_mask_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            forced_reg    <= forced_next;
            timeout_reg   <= timeout_next;
            lease_cnt_reg <= lease_cnt_next;
            win_idx_reg   <= win_idx_next;
            to_mask_reg   <= to_mask_next;
        end
    end

endmodule

// File: tb/tb_force_override_ctrl.sv
// Directed bench: a vector table on a HOLD_MAX=15 instance, then hand sequences for
// combinational tracking, timeout lock-out and release/timeout coincidence on a HOLD_MAX=3 one.
module tb_force_override_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] func_val;
    logic [3:0] req;
    logic [3:0] req_h3;
    logic [7:0] force_val;
    logic [3:0] grant, grant_h3;
    logic       forced, forced_h3;
    logic [1:0] out_val, out_val_h3;
    logic       timeout, timeout_h3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    force_override_ctrl #(.N_REQ(4), .WIDTH(2), .HOLD_MAX(15), .CNT_W(4)) dut (
        .clk(clk), .rstn(rstn), .func_val(func_val), .req(req), .force_val(force_val),
        .grant(grant), .forced(forced), .out_val(out_val), .timeout(timeout)
    );

    force_override_ctrl #(.N_REQ(4), .WIDTH(2), .HOLD_MAX(3), .CNT_W(4)) dut_h3 (
        .clk(clk), .rstn(rstn), .func_val(func_val), .req(req_h3), .force_val(force_val),
        .grant(grant_h3), .forced(forced_h3), .out_val(out_val_h3), .timeout(timeout_h3)
    );

    typedef struct {
        logic       rstn;
        logic [3:0] req;
        logic [7:0] fv;
        logic [1:0] func;
        logic [3:0] grant;
        logic       forced;
        logic [1:0] outv;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [7:0] fv,
                                input logic [1:0] fn, input logic [3:0] g, input logic f,
                                input logic [1:0] o, input logic t);
        vec_t v;
        v.rstn = r; v.req = q; v.fv = fv; v.func = fn;
        v.grant = g; v.forced = f; v.outv = o; v.to = t;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_h3(input string name, input logic [3:0] g, input logic f,
                          input logic [1:0] o, input logic t);
        $display("%s: req_h3=%b grant=%b forced=%b out=%b timeout=%b",
                 name, req_h3, grant_h3, forced_h3, out_val_h3, timeout_h3);
        check({name, " grant"},   32'(grant_h3),   32'(g));
        check({name, " forced"},  32'(forced_h3),  32'(f));
        check({name, " out_val"}, 32'(out_val_h3), 32'(o));
        check({name, " timeout"}, 32'(timeout_h3), 32'(t));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; req = '0; req_h3 = '0; force_val = '0; func_val = 2'd2;

        // reset
        vecs.push_back(mk(0, 4'h0, 8'h00, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(0, 4'h0, 8'h00, 2, 4'h0, 0, 2, 0));
        // single request, three forced cycles then release
        vecs.push_back(mk(1, 4'h1, 8'h01, 2, 4'h1, 1, 1, 0));
        vecs.push_back(mk(1, 4'h1, 8'h01, 2, 4'h1, 1, 1, 0));
        vecs.push_back(mk(1, 4'h1, 8'h01, 2, 4'h1, 1, 1, 0));
        vecs.push_back(mk(1, 4'h0, 8'h01, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'h0, 8'h01, 2, 4'h0, 0, 2, 0));
        // contention from a fresh pointer: slices 0..3 = 01,11,00,11
        vecs.push_back(mk(0, 4'h0, 8'hCD, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h1, 1, 1, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h1, 1, 1, 0));
        vecs.push_back(mk(1, 4'hE, 8'hCD, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h2, 1, 3, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h2, 1, 3, 0));
        vecs.push_back(mk(1, 4'hD, 8'hCD, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h4, 1, 0, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h4, 1, 0, 0));
        vecs.push_back(mk(1, 4'hB, 8'hCD, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h8, 1, 3, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h8, 1, 3, 0));
        vecs.push_back(mk(1, 4'h7, 8'hCD, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h1, 1, 1, 0));
        vecs.push_back(mk(1, 4'hF, 8'hCD, 2, 4'h1, 1, 1, 0));
        vecs.push_back(mk(1, 4'h0, 8'hCD, 2, 4'h0, 0, 2, 0));
        vecs.push_back(mk(1, 4'h0, 8'hCD, 2, 4'h0, 0, 2, 0));
        // live value tracking on requester 1; func_val ignored until GAP
        vecs.push_back(mk(1, 4'h2, 8'h04, 2, 4'h2, 1, 1, 0));
        vecs.push_back(mk(1, 4'h2, 8'h0C, 2, 4'h2, 1, 3, 0));
        vecs.push_back(mk(1, 4'h2, 8'h0C, 0, 4'h2, 1, 3, 0));
        vecs.push_back(mk(1, 4'h0, 8'h0C, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h0C, 1, 4'h0, 0, 1, 0));
        // reset in the second forced cycle, then pointer restarts at 0
        vecs.push_back(mk(1, 4'h4, 8'h20, 1, 4'h4, 1, 2, 0));
        vecs.push_back(mk(0, 4'h4, 8'h20, 1, 4'h0, 0, 1, 0));
        vecs.push_back(mk(1, 4'hF, 8'h23, 1, 4'h1, 1, 3, 0));
        vecs.push_back(mk(1, 4'h0, 8'h23, 1, 4'h0, 0, 1, 0));
        vecs.push_back(mk(1, 4'h0, 8'h23, 1, 4'h0, 0, 1, 0));

        foreach (vecs[i]) begin
            rstn = vecs[i].rstn; req = vecs[i].req;
            force_val = vecs[i].fv; func_val = vecs[i].func;
            tick();
            $display("row %0d: rstn=%b req=%b grant=%b forced=%b out=%b timeout=%b",
                     i, rstn, req, grant, forced, out_val, timeout);
            check($sformatf("row%0d grant", i),   32'(grant),   32'(vecs[i].grant));
            check($sformatf("row%0d forced", i),  32'(forced),  32'(vecs[i].forced));
            check($sformatf("row%0d out_val", i), 32'(out_val), 32'(vecs[i].outv));
            check($sformatf("row%0d timeout", i), 32'(timeout), 32'(vecs[i].to));
        end

        // combinational tracking inside a cycle
        req = 4'h1; force_val = 8'h01; func_val = 2'd2;
        tick();
        check("comb grant", 32'(grant), 32'h1);
        check("comb out 01", 32'(out_val), 32'h1);
        force_val = 8'h03;
        #1;
        check("comb out 11", 32'(out_val), 32'h3);
        func_val = 2'd0;
        #1;
        check("comb func ignored", 32'(out_val), 32'h3);
        req = 4'h0;
        tick();
        check("comb gap out", 32'(out_val), 32'h0);
        func_val = 2'd3;
        #1;
        check("comb gap func", 32'(out_val), 32'h3);
        $display("comb: grant=%b forced=%b out=%b", grant, forced, out_val);
        tick();

        // timeout on requester 2 with HOLD_MAX=3, then lock-out until req drops
        func_val = 2'd2; force_val = 8'h10; req_h3 = 4'h4;
        tick(); chk_h3("to lease1", 4'h4, 1, 1, 0);
        tick(); chk_h3("to lease2", 4'h4, 1, 1, 0);
        tick(); chk_h3("to lease3", 4'h4, 1, 1, 0);
        tick(); chk_h3("to cut",    4'h0, 0, 2, 1);
        tick(); chk_h3("to idle",   4'h0, 0, 2, 0);
        tick(); chk_h3("to masked1", 4'h0, 0, 2, 0);
        tick(); chk_h3("to masked2", 4'h0, 0, 2, 0);
        req_h3 = 4'h0;
        tick(); chk_h3("to dropped", 4'h0, 0, 2, 0);
        req_h3 = 4'h4;
        tick(); chk_h3("to regrant", 4'h4, 1, 1, 0);
        req_h3 = 4'h0;
        tick(); chk_h3("to release", 4'h0, 0, 2, 0);
        tick();

        // release on the HOLD_MAX cycle: no pulse, no mask
        force_val = 8'h08; req_h3 = 4'h2;
        tick(); chk_h3("rel lease1", 4'h2, 1, 2, 0);
        tick(); chk_h3("rel lease2", 4'h2, 1, 2, 0);
        tick(); chk_h3("rel lease3", 4'h2, 1, 2, 0);
        req_h3 = 4'h0;
        tick(); chk_h3("rel gap", 4'h0, 0, 2, 0);
        req_h3 = 4'h2;
        tick(); chk_h3("rel idle", 4'h0, 0, 2, 0);
        tick(); chk_h3("rel regrant", 4'h2, 1, 2, 0);
        req_h3 = 4'h0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
